// File: rtl/cache_refill_responder.sv
// rtl/cache_refill_responder.sv - backing memory responder for I-cache and D-cache line refills and write-backs
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   rst       asynchronous active-low reset
//   i_req     I-cache line-read request, held until i_done
//   i_addr    I-cache word address (line offset bits ignored)
//   i_rvalid  I-cache read beat valid
//   i_rdata   I-cache read beat data
//   i_done    one-cycle I-cache completion pulse
//   d_req     D-cache request, held until d_done
//   d_we      1 = line write-back, 0 = line read
//   d_addr    D-cache word address (line offset bits ignored)
//   d_wdata   write-back beat data, valid whenever d_wready is high
//   d_wready  write beat consumed at the end of this cycle
//   d_rvalid  D-cache read beat valid
//   d_rdata   D-cache read beat data
//   d_done    one-cycle D-cache completion pulse
//   busy      high whenever a transaction is in progress

module cache_refill_responder #(
    parameter int ADDR_W         = 30,
    parameter int WORDS_PER_LINE = 4,
    parameter int LATENCY        = 4,
    parameter int DEPTH          = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_wready,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic              busy
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LN_W  = IDX_W - OFF_W;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_XFER,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  lat_q;
    logic [OFF_W-1:0]  beat_q;
    logic [LN_W-1:0]   line_q;
    logic              own_d_q;
    logic              we_q;
    logic              i_rvalid_q;
    logic [31:0]       i_rdata_q;
    logic              i_done_q;
    logic              d_wready_q;
    logic              d_rvalid_q;
    logic [31:0]       d_rdata_q;
    logic              d_done_q;
    logic              busy_q;

    logic [31:0]       mem [0:DEPTH-1];

    logic [OFF_W-1:0]  beat_d;
    logic              last_beat;
    logic              present_d;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic [31:0]       rd_word;
    logic              i_beat;
    logic              d_rd_beat;
    logic              d_wr_beat;
    logic              unused_addr_bits;

    // Only the line index inside the memory matters: offset bits are replaced
    // by the beat counter and bits above the memory size wrap away.
    assign unused_addr_bits = ^{i_addr[ADDR_W-1:IDX_W], i_addr[OFF_W-1:0],
                                d_addr[ADDR_W-1:IDX_W], d_addr[OFF_W-1:0]};

    assign beat_d    = beat_q + 1'b1;
    assign last_beat = (beat_q == OFF_W'(WORDS_PER_LINE - 1));

    // A beat is presented in the cycle after this one: either the first beat
    // when WAIT expires, or the next beat while XFER still has beats left.
    assign present_d = ((state_q == S_WAIT) && (lat_q == '0)) ||
                       ((state_q == S_XFER) && !last_beat);

    // Beat index is concatenated below the aligned line, so (base + k) wraps
    // inside the memory without an adder.
    assign rd_idx  = (state_q == S_WAIT) ? {line_q, {OFF_W{1'b0}}} : {line_q, beat_d};
    assign wr_idx  = {line_q, beat_q};
    assign rd_word = mem[rd_idx];

    assign i_beat    = ~own_d_q;
    assign d_rd_beat = own_d_q & ~we_q;
    assign d_wr_beat = own_d_q & we_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            lat_q      <= '0;
            beat_q     <= '0;
            line_q     <= '0;
            own_d_q    <= 1'b0;
            we_q       <= 1'b0;
            i_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            i_done_q   <= 1'b0;
            d_wready_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
            d_done_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            i_rvalid_q <= present_d & i_beat;
            i_rdata_q  <= (present_d & i_beat) ? rd_word : '0;
            d_rvalid_q <= present_d & d_rd_beat;
            d_rdata_q  <= (present_d & d_rd_beat) ? rd_word : '0;
            d_wready_q <= present_d & d_wr_beat;

            unique case (state_q)
                S_IDLE: begin
                    // D-cache wins ties; the loser keeps its request up.
                    if (d_req) begin
                        own_d_q <= 1'b1;
                        we_q    <= d_we;
                        line_q  <= d_addr[IDX_W-1:OFF_W];
                        lat_q   <= CNT_W'(LATENCY - 1);
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end else if (i_req) begin
                        own_d_q <= 1'b0;
                        we_q    <= 1'b0;
                        line_q  <= i_addr[IDX_W-1:OFF_W];
                        lat_q   <= CNT_W'(LATENCY - 1);
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_q == '0) begin
                        beat_q  <= '0;
                        state_q <= S_XFER;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                S_XFER: begin
                    if (last_beat) begin
                        i_done_q <= ~own_d_q;
                        d_done_q <= own_d_q;
                        state_q  <= S_DONE;
                    end else begin
                        beat_q <= beat_d;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The write strobe is the registered d_wready, so a reset that clears it
    // also suppresses the write of the beat in flight.
    always_ff @(posedge clk) begin
        if (d_wready_q) begin
            mem[wr_idx] <= d_wdata;
        end
    end

    assign i_rvalid = i_rvalid_q;
    assign i_rdata  = i_rdata_q;
    assign i_done   = i_done_q;
    assign d_wready = d_wready_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;
    assign d_done   = d_done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_cache_refill_responder.sv
// tb/tb_cache_refill_responder.sv - randomized self-checking bench for cache_refill_responder

module tb_cache_refill_responder;

    localparam int AW = 30;
    localparam int W  = 4;
    localparam int L  = 4;
    localparam int D  = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_rvalid;
    logic [31:0]   i_rdata;
    logic          i_done;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic          d_wready;
    logic          d_rvalid;
    logic [31:0]   d_rdata;
    logic          d_done;
    logic          busy;

    cache_refill_responder #(
        .ADDR_W(AW), .WORDS_PER_LINE(W), .LATENCY(L), .DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wready(d_wready),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_done(d_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected outputs for the cycle that follows a given rising edge.
    typedef struct packed {
        bit          busy;
        bit          own_d;
        bit          iv;
        bit          dv;
        bit          wr;
        bit          idn;
        bit          ddn;
        logic [31:0] idat;
        logic [31:0] ddat;
        logic [31:0] wdat;
        int          widx;
    } exp_t;

    exp_t        ring [64];
    exp_t        cmp_e;
    logic [31:0] mmem [D];
    logic [31:0] wline [4];
    int          cyc = 0;
    int          free_at = 0;
    int          total = 0;
    int          bad = 0;

    int          tn, wcnt, wfirst, wlast, ifirst, idone_t, ddone_t;
    logic [31:0] iq [$];
    logic [31:0] dq [$];

    function automatic void chk1(string nm, logic act, logic expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    function automatic void chk32(string nm, logic [31:0] act, logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    function automatic void chki(string nm, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    // Transaction-level model: on an accepted request, lay the whole
    // transaction out on the timeline from the latency/beat-count rules.
    task automatic schedule();
        bit od;
        bit we;
        int a;
        int base;
        int e;
        od   = d_req;
        we   = od ? d_we : 1'b0;
        a    = od ? int'(d_addr) : int'(i_addr);
        base = ((a / W) * W) % D;
        for (int j = 0; j <= L + W; j++) begin
            ring[(cyc + j) & 63].busy  = 1'b1;
            ring[(cyc + j) & 63].own_d = od;
        end
        for (int k = 0; k < W; k++) begin
            e = (cyc + L + k) & 63;
            if (!od) begin
                ring[e].iv   = 1'b1;
                ring[e].idat = mmem[(base + k) % D];
            end else if (we) begin
                ring[e].wr   = 1'b1;
                ring[e].widx = (base + k) % D;
                ring[e].wdat = wline[k];
            end else begin
                ring[e].dv   = 1'b1;
                ring[e].ddat = mmem[(base + k) % D];
            end
        end
        if (od) ring[(cyc + L + W) & 63].ddn = 1'b1;
        else    ring[(cyc + L + W) & 63].idn = 1'b1;
        free_at = cyc + L + W + 2;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ring[i] = '0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (!rst) begin
                for (int i = 0; i < 64; i++) ring[i] = '0;
                free_at = 0;
            end else begin
                if (ring[(cyc - 1) & 63].wr)
                    mmem[ring[(cyc - 1) & 63].widx] = ring[(cyc - 1) & 63].wdat;
                ring[(cyc - 1) & 63] = '0;
                if (cyc >= free_at && (d_req || i_req)) schedule();
            end
        end
    end

    initial begin
        #4;
        forever begin
            @(negedge clk);
            cmp_e = ring[cyc & 63];
            chk1("i_rvalid", i_rvalid, cmp_e.iv);
            chk1("d_rvalid", d_rvalid, cmp_e.dv);
            chk1("d_wready", d_wready, cmp_e.wr);
            chk1("i_done", i_done, cmp_e.idn);
            chk1("d_done", d_done, cmp_e.ddn);
            chk1("busy", busy, cmp_e.busy);
            if (cmp_e.iv) chk32("i_rdata", i_rdata, cmp_e.idat);
            if (cmp_e.dv) chk32("d_rdata", d_rdata, cmp_e.ddat);
            if (cmp_e.busy && cmp_e.own_d)  chk32("i_rdata_nonowner", i_rdata, 32'h0);
            if (cmp_e.busy && !cmp_e.own_d) chk32("d_rdata_nonowner", d_rdata, 32'h0);
            if (!rst) begin
                chk32("i_rdata_reset", i_rdata, 32'h0);
                chk32("d_rdata_reset", d_rdata, 32'h0);
            end
        end
    end

    task automatic clear_log();
        tn = 0; wcnt = 0; wfirst = -1; wlast = -1; ifirst = -1; idone_t = -1; ddone_t = -1;
        iq.delete();
        dq.delete();
    endtask

    // One cycle of both cache initiators: feed write beats, capture read
    // beats, drop req when done is seen.
    task automatic tick();
        @(negedge clk);
        tn++;
        if (d_wready === 1'b1) begin
            d_wdata = wline[wcnt & 3];
            wcnt++;
            if (wfirst < 0) wfirst = tn;
            wlast = tn;
        end else begin
            d_wdata = $urandom;
        end
        if (i_rvalid === 1'b1) begin
            iq.push_back(i_rdata);
            if (ifirst < 0) ifirst = tn;
        end
        if (d_rvalid === 1'b1) dq.push_back(d_rdata);
        if (i_done === 1'b1) begin idone_t = tn; i_req = 1'b0; end
        if (d_done === 1'b1) begin ddone_t = tn; d_req = 1'b0; end
        if (!i_req) i_addr = AW'($urandom);
    endtask

    task automatic run_until_idle();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((i_req || d_req) && n < 300);
        if (n >= 300) begin
            chki("run_timeout", n, 0);
            i_req = 1'b0;
            d_req = 1'b0;
        end
        tick();
    endtask

    task automatic d_write(input logic [AW-1:0] a, input logic [31:0] w [4]);
        wline = w;
        clear_log();
        d_addr = a; d_we = 1'b1; d_req = 1'b1;
        run_until_idle();
    endtask

    task automatic d_read(input logic [AW-1:0] a);
        clear_log();
        d_addr = a; d_we = 1'b0; d_req = 1'b1;
        run_until_idle();
    endtask

    task automatic check_q(string nm, input logic [31:0] got [$], input logic [31:0] ev [4]);
        chki({nm, "_count"}, got.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < got.size()) chk32(nm, got[k], ev[k]);
    endtask

    task automatic rand_txn();
        int mode;
        int dly;
        logic [31:0] w [4];
        mode = $urandom_range(0, 4);
        dly  = $urandom_range(0, 12);
        for (int k = 0; k < 4; k++) w[k] = $urandom;
        wline  = w;
        d_we   = 1'($urandom);
        d_addr = AW'($urandom);
        i_addr = AW'($urandom);
        clear_log();
        case (mode)
            0: i_req = 1'b1;
            1: d_req = 1'b1;
            2: begin i_req = 1'b1; d_req = 1'b1; end
            3: begin i_req = 1'b1; repeat (dly) tick(); d_req = 1'b1; end
            default: begin d_req = 1'b1; repeat (dly) tick(); i_addr = AW'($urandom); i_req = 1'b1; end
        endcase
        run_until_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] a;
        logic [31:0]   w [4];
        int            n;

        clear_log();
        #3 rst = 1'b0;
        @(negedge clk);
        chk32("reset_outputs", {26'h0, i_rvalid, i_done, d_wready, d_rvalid, d_done, busy}, 32'h0);
        chk32("reset_rdata", i_rdata | d_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Fill every line so every later read has a known model value.
        for (int line = 0; line < D / W; line++) begin
            for (int k = 0; k < 4; k++) w[k] = $urandom;
            a = AW'($urandom);
            a[9:2] = 8'(line);
            d_write(a, w);
        end

        // I-cache refill of line 0x40 with a misaligned address.
        d_write(30'h40, '{32'hA0, 32'hA1, 32'hA2, 32'hA3});
        clear_log();
        i_addr = 30'h42; i_req = 1'b1;
        run_until_idle();
        check_q("irefill_data", iq, '{32'hA0, 32'hA1, 32'hA2, 32'hA3});
        chki("irefill_first_beat", ifirst, 5);
        chki("irefill_done", idone_t, 9);
        chki("irefill_d_quiet", dq.size() + wcnt + ((ddone_t >= 0) ? 1 : 0), 0);

        // Simultaneous requests: D first, I after one idle cycle.
        clear_log();
        d_addr = 30'h10; d_we = 1'b0; i_addr = 30'h80;
        i_req = 1'b1; d_req = 1'b1;
        run_until_idle();
        chki("simul_d_done", ddone_t, 9);
        chki("simul_i_first", ifirst, 15);
        chki("simul_i_done", idone_t, 19);

        // Write-back then read of the same line.
        d_write(30'h20, '{32'd11, 32'd22, 32'd33, 32'd44});
        chki("wb_beats", wcnt, 4);
        chki("wb_first", wfirst, 5);
        chki("wb_consecutive", wlast - wfirst, 3);
        d_read(30'h23);
        check_q("raw_data", dq, '{32'd11, 32'd22, 32'd33, 32'd44});

        // Wrap-around at the top of memory and upper address bits ignored.
        d_write(30'h3FC, '{32'h3FC0, 32'h3FC1, 32'h3FC2, 32'h3FC3});
        d_write(30'h001, '{32'hF00, 32'hF01, 32'hF02, 32'hF03});
        d_read(30'h3FE);
        check_q("wrap_3fe", dq, '{32'h3FC0, 32'h3FC1, 32'h3FC2, 32'h3FC3});
        d_read(30'h400);
        check_q("wrap_400", dq, '{32'hF00, 32'hF01, 32'hF02, 32'hF03});
        clear_log();
        i_addr = 30'h200_03FD; i_req = 1'b1;
        run_until_idle();
        check_q("wrap_upper_bits", iq, '{32'h3FC0, 32'h3FC1, 32'h3FC2, 32'h3FC3});

        // Reset during beat 2 of a write-back.
        d_write(30'h30, '{32'hD00, 32'hD01, 32'hD02, 32'hD03});
        wline = '{32'hE00, 32'hE01, 32'hE02, 32'hE03};
        clear_log();
        d_addr = 30'h30; d_we = 1'b1; d_req = 1'b1;
        n = 0;
        while (wcnt < 3 && n < 50) begin tick(); n++; end
        chki("rst_reach_beat2", wcnt, 3);
        #2 rst = 1'b0;
        d_req = 1'b0;
        #1;
        chk32("rst_async_outputs", {26'h0, i_rvalid, i_done, d_wready, d_rvalid, d_done, busy}, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        chki("rst_no_done", ddone_t, -1);
        d_read(30'h30);
        check_q("rst_partial_write", dq, '{32'hE00, 32'hE01, 32'hD02, 32'hD03});

        // Request dropped while in WAIT still completes.
        clear_log();
        i_addr = 30'h55; i_req = 1'b1;
        tick();
        tick();
        i_req = 1'b0;
        n = 0;
        while (idone_t < 0 && n < 40) begin tick(); n++; end
        chki("drop_done", idone_t, 9);
        tick();
        chk1("drop_busy_idle", busy, 1'b0);

        for (int t = 0; t < 80; t++) rand_txn();

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_refill_responder.md
Name: cache_refill_responder

Overview:
- Backing main-memory responder at the memory end of the instruction-cache and data-cache miss interfaces.
- Accepts line-refill reads from the I-cache, and line-refill reads or line write-backs from the D-cache.
- Arbitrates between the two caches, models a fixed access latency, and transfers one cache line as WORDS_PER_LINE single-word beats.
- Closes the loop that drives the pipeline's ins_hit/data_hit stalls.

Parameters:
- ADDR_W, 30: word-address width, matching the pipeline's 30-bit PC/word addresses.
- WORDS_PER_LINE, 4: beats per line; power of two, at least 2.
- LATENCY, 4: cycles spent in WAIT before the first beat; at least 1.
- DEPTH, 1024: memory size in 32-bit words; power of two.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  I-cache line-read request; held high until i_done.
- i_addr  in  ADDR_W  I-cache word address; the low log2(WORDS_PER_LINE) bits are ignored.
- i_rvalid  out  1  I-cache read beat valid.
- i_rdata  out  32  I-cache read beat data.
- i_done  out  1  one-cycle I-cache completion pulse.
- d_req  in  1  D-cache request; held high until d_done.
- d_we  in  1  1 = line write-back, 0 = line read.
- d_addr  in  ADDR_W  D-cache word address; low bits ignored as for i_addr.
- d_wdata  in  32  write-back beat data; must be valid whenever d_wready is high.
- d_wready  out  1  write beat consumed at this edge.
- d_rvalid  out  1  D-cache read beat valid.
- d_rdata  out  32  D-cache read beat data.
- d_done  out  1  one-cycle D-cache completion pulse.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- States: IDLE, WAIT, XFER, DONE. All outputs are registered.
- Reset (rst=0, asynchronous):
  - state = IDLE; all valid, ready and done outputs = 0; rdata outputs = 0; counters = 0.
  - Memory array contents are not cleared.
  - Reset during any state aborts the transaction: no done pulse, no further writes.
- IDLE, arbitration:
  - d_req has fixed priority over i_req.
  - On the edge where the selected request is high, latch the owner, d_we (0 for I-cache) and base address = addr with the low log2(WORDS_PER_LINE) bits cleared.
  - Load the latency counter with LATENCY-1 and go to WAIT.
  - The loser keeps its req high and is served after DONE.
- WAIT:
  - Decrement the counter each cycle; go to XFER when it is 0. WAIT lasts exactly LATENCY cycles.
  - Clear the beat counter on exit.
- XFER, beat k = 0..WORDS_PER_LINE-1, one beat per cycle:
  - Word index = (base + k) mod DEPTH. The address wraps on the low log2(DEPTH) bits; upper address bits are ignored.
  - Read: the owner's rvalid = 1 and rdata = mem[index] in that cycle.
  - Write: d_wready = 1; mem[index] <= d_wdata at the end of that cycle.
  - After the last beat, go to DONE.
- DONE:
  - The owner's done = 1 for exactly one cycle, then go to IDLE.
  - The initiator deasserts req at the edge that samples done=1.
  - The IDLE cycle after DONE re-arbitrates, so back-to-back transactions have one idle cycle between them.
- Non-owner outputs stay 0 throughout. At most one of i_rvalid, d_rvalid, d_wready is high in any cycle.
- After a transaction is latched, changes to req, addr or we are ignored until DONE. Dropping req early does not abort.
- Timing, with the request sampled at edge 0:
  - Beat 0 is valid in cycle LATENCY+1.
  - done is high in cycle LATENCY+WORDS_PER_LINE+1.
  - With the defaults: beats in cycles 5–8, done in cycle 9.
- Read-after-write: a D-cache read issued after a write-back's d_done returns the written data.

Test Plan:
- I-cache refill: preload mem[0x40..0x43] = A0..A3, i_req=1 with i_addr=0x42. Required: i_rvalid high in cycles 5–8 with A0, A1, A2, A3; i_done in cycle 9; d_* outputs stay 0.
- Simultaneous requests: i_req and d_req (read, addr 0x10) rise on the same edge. Required: the D line is served first (d_done at cycle 9). I is sampled in the IDLE cycle after that DONE, and its done follows LATENCY+WORDS_PER_LINE+1 cycles later.
- Write-back then read: d_we=1, d_addr=0x20, wdata beats 11,22,33,44, then d_we=0 on the same line. Required: d_wready high for 4 consecutive cycles; the read returns 11,22,33,44.
- Wrap-around with DEPTH=1024: d_addr=0x3FE read. Required: the base aligns to 0x3FC and beats return mem[0x3FC..0x3FF]. Also with d_addr=0x400, beats return mem[0x000..0x003].
- Reset mid-XFER: assert rst=0 during beat 2 of a write. Required:
  - All outputs are 0 immediately, without waiting for a clock edge.
  - Only beats 0–1 have been written.
  - No done pulse.
  - A new request after reset release is served normally.
- Request dropped early: i_req goes low in WAIT. Required: the transaction still completes with i_done, then the block returns to IDLE and busy=0.
